// File: rtl/jamma_joy_scan.sv
// Shared JAMMA joystick bus scanner: drives JSELECT round-robin, samples
// JJOY after a settle window, and debounces each player's vector across scans.
module jamma_joy_scan #(
    parameter int unsigned PLAYERS  = 2,
    parameter int unsigned JOY_W    = 8,
    parameter int unsigned SETTLE   = 0,
    parameter int unsigned DEBOUNCE = 1,
    parameter int unsigned SEL_W    = (PLAYERS > 1) ? $clog2(PLAYERS) : 1
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic                       ENABLE,
    input  logic [JOY_W-1:0]           JJOY,
    input  logic [JOY_W-1:0]           LOCAL_JOY,
    output logic [SEL_W-1:0]           JSELECT,
    output logic [PLAYERS*JOY_W-1:0]   JOY_OUT,
    output logic                       SCAN_DONE
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned M_W   = 4;

    logic [SEL_W-1:0]                sel_q,  sel_d;
    logic [CNT_W-1:0]                cnt_q,  cnt_d;
    logic [PLAYERS-1:0][JOY_W-1:0]   last_q, last_d;
    logic [PLAYERS-1:0][M_W-1:0]     m_q,    m_d;
    logic [PLAYERS*JOY_W-1:0]        joy_q,  joy_d;
    logic                            done_q, done_d;

    logic [JOY_W-1:0]                sample_c;
    logic [M_W-1:0]                  m_new_c;

    // Slot timing, player rotation and per-player debounce update
    always_comb begin
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        m_d      = m_q;
        joy_d    = joy_q;
        done_d   = 1'b0;
        m_new_c  = '0;
        // Local stick is only wired alongside player 0
        sample_c = JJOY & ((sel_q == '0) ? LOCAL_JOY : {JOY_W{1'b1}});

        if (ENABLE) begin
            if (cnt_q == '0) begin
                cnt_d = CNT_W'(SETTLE);
                if (sel_q == SEL_W'(PLAYERS - 1)) begin
                    sel_d  = '0;
                    done_d = 1'b1;
                end else begin
                    sel_d = sel_q + SEL_W'(1);
                end

                for (int p = 0; p < PLAYERS; p++) begin
                    if (sel_q == SEL_W'(p)) begin
                        if (sample_c != last_q[p]) begin
                            last_d[p] = sample_c;
                            m_new_c   = M_W'(1);
                        end else if (m_q[p] >= M_W'(DEBOUNCE)) begin
                            m_new_c   = M_W'(DEBOUNCE);
                        end else begin
                            m_new_c   = m_q[p] + M_W'(1);
                        end
                        m_d[p] = m_new_c;
                        if (m_new_c == M_W'(DEBOUNCE)) begin
                            joy_d[p*JOY_W +: JOY_W] = sample_c;
                        end
                    end
                end
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // State registers; outputs released (all ones) in reset
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sel_q  <= '0;
            cnt_q  <= CNT_W'(SETTLE);
            last_q <= '1;
            m_q    <= '0;
            joy_q  <= '1;
            done_q <= 1'b0;
        end else begin
            sel_q  <= sel_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
            m_q    <= m_d;
            joy_q  <= joy_d;
            done_q <= done_d;
        end
    end

    assign JSELECT   = sel_q;
    assign JOY_OUT   = joy_q;
    assign SCAN_DONE = done_q;

endmodule
